branch_resolve_unit: RTL and testbench

Parametrised branch resolution unit for the execute stage: compares two XLEN-bit operands per RV32I/RV64I branch func3, registers the outcome behind a valid/ready handshake, and trains a direct-mapped table of 2-bit saturating counters that supplies a combinational taken/not-taken prediction to fetch. Sits between ID/EX and the PC-select logic. Reports mispredicts against the prediction fetch made.

---
 rtl/branch_resolve_unit.sv | 181 ++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Branch resolution for the execute stage: RV32I/RV64I condition compare, single-entry skid
// output register and a direct-mapped 2-bit counter table. Optional perf counters: BRU_PERF_CNT_EN.
module branch_resolve_unit #(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned PC_W        = 32,
   parameter int unsigned BHT_ENTRIES = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [PC_W-1:0] pred_pc,
   output logic            pred_taken,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            in_branch,
   input  logic [2:0]      in_func3,
   input  logic [XLEN-1:0] in_a,
   input  logic [XLEN-1:0] in_b,
   input  logic [PC_W-1:0] in_pc,
   input  logic            in_pred,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            out_taken,
   output logic            out_mispredict,
   output logic            out_illegal
`ifdef BRU_PERF_CNT_EN
   ,
   output logic [31:0]     perf_branches,
   output logic [31:0]     perf_mispredicts
`endif
);

   localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);
   localparam int unsigned CNT_W = 2;
   localparam logic [CNT_W-1:0] CNT_WNT = 2'b01;
   localparam logic [CNT_W-1:0] CNT_ST  = 2'b11;
   localparam logic [CNT_W-1:0] CNT_SNT = 2'b00;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   logic [XLEN:0]      w_diff;
   logic [XLEN-1:0]    w_res;
   logic               w_carry;
   logic               w_ovf;
   logic               w_eq;
   logic               w_lt_s;
   logic               w_lt_u;
   logic               w_cond;
   logic               w_illegal;
   logic               w_taken;
   logic               w_mispredict;
   logic               w_accept;
   logic               w_update;
   logic [IDX_W-1:0]   w_upd_idx;
   logic [IDX_W-1:0]   w_pred_idx;
   logic [CNT_W-1:0]   w_cnt_cur;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic               w_unused_pc;

   logic [CNT_W-1:0]   r_bht [BHT_ENTRIES];
   logic               r_out_valid;
   logic               r_out_taken;
   logic               r_out_mispredict;
   logic               r_out_illegal;

   // a - b as a + ~b + 1 with one extra bit to capture the carry out
   assign w_diff  = {1'b0, in_a} + {1'b0, ~in_b} + (XLEN+1)'(1);
   assign w_res   = w_diff[XLEN-1:0];
   assign w_carry = w_diff[XLEN];
   assign w_ovf   = (in_a[XLEN-1] ^ in_b[XLEN-1]) & (w_res[XLEN-1] ^ in_a[XLEN-1]);
   assign w_eq    = (w_res == '0);
   assign w_lt_s  = w_res[XLEN-1] ^ w_ovf;
   assign w_lt_u  = ~w_carry;

   always_comb begin
      w_cond = 1'b0;
      case (in_func3)
         F3_BEQ:  w_cond = w_eq;
         F3_BNE:  w_cond = ~w_eq;
         F3_BLT:  w_cond = w_lt_s;
         F3_BGE:  w_cond = ~w_lt_s;
         F3_BLTU: w_cond = w_lt_u;
         F3_BGEU: w_cond = ~w_lt_u;
         default: w_cond = 1'b0;
      endcase
   end

   assign w_illegal    = in_branch & (in_func3[2:1] == 2'b01);
   assign w_taken      = in_branch & ~w_illegal & w_cond;
   assign w_mispredict = in_branch & (w_taken ^ in_pred);

   assign in_ready = ~r_out_valid | out_ready;
   assign w_accept = in_valid & in_ready & ~flush;
   assign w_update = w_accept & in_branch & ~w_illegal;

   assign w_upd_idx  = in_pc[IDX_W+1:2];
   assign w_pred_idx = pred_pc[IDX_W+1:2];
   assign w_unused_pc = ^{in_pc[1:0], pred_pc[1:0], in_pc[PC_W-1:IDX_W+2], pred_pc[PC_W-1:IDX_W+2]};

   assign pred_taken = r_bht[w_pred_idx][CNT_W-1];

   // Saturating counter step for the entry being trained
   always_comb begin
      w_cnt_cur = r_bht[w_upd_idx];
      w_cnt_nxt = w_cnt_cur;
      if (w_taken) begin
         if (w_cnt_cur != CNT_ST) w_cnt_nxt = w_cnt_cur + CNT_W'(1);
      end else begin
         if (w_cnt_cur != CNT_SNT) w_cnt_nxt = w_cnt_cur - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(BHT_ENTRIES); i++) r_bht[i] <= CNT_WNT;
      end else if (w_update) begin
         r_bht[w_upd_idx] <= w_cnt_nxt;
      end
   end

   // Single-entry output register; flush wins over both hold and a concurrent accept
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid      <= 1'b0;
         r_out_taken      <= 1'b0;
         r_out_mispredict <= 1'b0;
         r_out_illegal    <= 1'b0;
      end else if (flush) begin
         r_out_valid      <= 1'b0;
      end else if (w_accept) begin
         r_out_valid      <= 1'b1;
         r_out_taken      <= w_taken;
         r_out_mispredict <= w_mispredict;
         r_out_illegal    <= w_illegal;
      end else if (out_ready) begin
         r_out_valid      <= 1'b0;
      end
   end

   assign out_valid      = r_out_valid;
   assign out_taken      = r_out_taken;
   assign out_mispredict = r_out_mispredict;
   assign out_illegal    = r_out_illegal;

`ifdef BRU_PERF_CNT_EN
   logic        r_out_branch;
   logic        w_handshake;
   logic [31:0] r_perf_branches;
   logic [31:0] r_perf_mispredicts;

   assign w_handshake = r_out_valid & out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_branch <= 1'b0;
      end else if (!flush && w_accept) begin
         r_out_branch <= in_branch;
      end
   end

   // Counted on the result handshake; flush does not clear them
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_perf_branches    <= 32'd0;
         r_perf_mispredicts <= 32'd0;
      end else begin
         if (w_handshake && r_out_branch)     r_perf_branches    <= r_perf_branches + 32'd1;
         if (w_handshake && r_out_mispredict) r_perf_mispredicts <= r_perf_mispredicts + 32'd1;
      end
   end

   assign perf_branches    = r_perf_branches;
   assign perf_mispredicts = r_perf_mispredicts;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit (XLEN=32, 64-entry table).
module tb_branch_resolve_unit;

   localparam int unsigned XLEN = 32;
   localparam int unsigned PC_W = 32;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [PC_W-1:0] pred_pc;
   logic            pred_taken;
   logic            in_valid;
   logic            in_ready;
   logic            in_branch;
   logic [2:0]      in_func3;
   logic [XLEN-1:0] in_a;
   logic [XLEN-1:0] in_b;
   logic [PC_W-1:0] in_pc;
   logic            in_pred;
   logic            flush;
   logic            out_valid;
   logic            out_ready;
   logic            out_taken;
   logic            out_mispredict;
   logic            out_illegal;
`ifdef BRU_PERF_CNT_EN
   logic [31:0]     perf_branches;
   logic [31:0]     perf_mispredicts;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   branch_resolve_unit #(.XLEN(XLEN), .PC_W(PC_W), .BHT_ENTRIES(64)) dut (
      .clk(clk), .rst_n(rst_n),
      .pred_pc(pred_pc), .pred_taken(pred_taken),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_branch(in_branch), .in_func3(in_func3),
      .in_a(in_a), .in_b(in_b), .in_pc(in_pc), .in_pred(in_pred),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_taken(out_taken), .out_mispredict(out_mispredict), .out_illegal(out_illegal)
`ifdef BRU_PERF_CNT_EN
      , .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
`endif
   );

   typedef struct {
      logic        br;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic        pred;
      logic        e_taken;
      logic        e_mis;
      logic        e_ill;
   } vec_t;

   localparam int NV = 13;
   vec_t vecs [NV];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic req(input logic br, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] pc, input logic pred);
      in_valid  = 1'b1;
      in_branch = br;
      in_func3  = f3;
      in_a      = a;
      in_b      = b;
      in_pc     = pc;
      in_pred   = pred;
   endtask

   logic outc   [10];
   logic exp_pt [10];

   initial begin
      vecs[0]  = '{1'b1, 3'b000, 32'd5,        32'd5,        1'b0, 1'b1, 1'b1, 1'b0};
      vecs[1]  = '{1'b1, 3'b001, 32'd5,        32'd5,        1'b0, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 3'b100, 32'hFFFFFFFF, 32'd1,        1'b0, 1'b1, 1'b1, 1'b0};
      vecs[3]  = '{1'b1, 3'b110, 32'hFFFFFFFF, 32'd1,        1'b1, 1'b0, 1'b1, 1'b0};
      vecs[4]  = '{1'b1, 3'b101, 32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{1'b1, 3'b111, 32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[6]  = '{1'b1, 3'b100, 32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[7]  = '{1'b1, 3'b000, 32'd3,        32'd4,        1'b1, 1'b0, 1'b1, 1'b0};
      vecs[8]  = '{1'b1, 3'b010, 32'd9,        32'd9,        1'b1, 1'b0, 1'b1, 1'b1};
      vecs[9]  = '{1'b1, 3'b011, 32'd1,        32'd2,        1'b0, 1'b0, 1'b0, 1'b1};
      vecs[10] = '{1'b0, 3'b000, 32'd7,        32'd7,        1'b1, 1'b0, 1'b0, 1'b0};
      vecs[11] = '{1'b1, 3'b101, 32'd7,        32'd7,        1'b1, 1'b1, 1'b0, 1'b0};
      vecs[12] = '{1'b1, 3'b110, 32'd0,        32'hFFFFFFFF, 1'b0, 1'b1, 1'b1, 1'b0};

      // Outcomes at pc 0x100 and the pred_taken expected just before each accept
      outc   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      exp_pt = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

      rst_n = 1'b0; pred_pc = 32'h100; in_valid = 1'b0; in_branch = 1'b0; in_func3 = 3'b000;
      in_a = '0; in_b = '0; in_pc = '0; in_pred = 1'b0; flush = 1'b0; out_ready = 1'b1;

      repeat (2) @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_taken", 64'(out_taken), 64'd0);
      chk("rst_out_mispredict", 64'(out_mispredict), 64'd0);
      chk("rst_out_illegal", 64'(out_illegal), 64'd0);
      chk("rst_pred_taken", 64'(pred_taken), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_in_ready", 64'(in_ready), 64'd1);

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         req(vecs[i].br, vecs[i].f3, vecs[i].a, vecs[i].b, 32'h204, vecs[i].pred);
         @(negedge clk);
         in_valid = 1'b0;
         chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
         chk($sformatf("vec%0d_taken", i), 64'(out_taken), 64'(vecs[i].e_taken));
         chk($sformatf("vec%0d_mispredict", i), 64'(out_mispredict), 64'(vecs[i].e_mis));
         chk($sformatf("vec%0d_illegal", i), 64'(out_illegal), 64'(vecs[i].e_ill));
      end

      // Back-to-back training at one index; pred_pc low bits must be ignored
      @(negedge clk);
      pred_pc = 32'h103;
      for (int k = 0; k < 10; k++) begin
         if (k > 0) @(negedge clk);
         if (k > 0) begin
            chk($sformatf("train%0d_valid", k), 64'(out_valid), 64'd1);
            chk($sformatf("train%0d_taken", k), 64'(out_taken), 64'(outc[k-1]));
         end
         chk($sformatf("train%0d_pred", k), 64'(pred_taken), 64'(exp_pt[k]));
         req(1'b1, outc[k] ? 3'b000 : 3'b001, 32'd7, 32'd7, 32'h100, exp_pt[k]);
      end
      @(negedge clk);
      in_valid = 1'b0;
      chk("train_last_taken", 64'(out_taken), 64'd1);
      chk("train_final_pred", 64'(pred_taken), 64'd1);

      // Backpressure: first result held, second request waits for out_ready
      @(negedge clk);
      out_ready = 1'b0;
      req(1'b1, 3'b000, 32'd1, 32'd1, 32'h308, 1'b0);
      @(negedge clk);
      chk("stall1_valid", 64'(out_valid), 64'd1);
      chk("stall1_taken", 64'(out_taken), 64'd1);
      chk("stall1_in_ready", 64'(in_ready), 64'd0);
      req(1'b1, 3'b000, 32'd1, 32'd2, 32'h308, 1'b0);
      @(negedge clk);
      chk("stall2_valid", 64'(out_valid), 64'd1);
      chk("stall2_taken_held", 64'(out_taken), 64'd1);
      chk("stall2_in_ready", 64'(in_ready), 64'd0);
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk("stall_second_valid", 64'(out_valid), 64'd1);
      chk("stall_second_taken", 64'(out_taken), 64'd0);
      @(negedge clk);
      chk("stall_drained", 64'(out_valid), 64'd0);

      // Flush with a concurrent accept: dropped, table untouched
      pred_pc = 32'h40C;
      req(1'b1, 3'b000, 32'd9, 32'd9, 32'h40C, 1'b0);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      in_valid = 1'b0;
      chk("flush_acc_valid", 64'(out_valid), 64'd0);
      chk("flush_acc_pred", 64'(pred_taken), 64'd0);

      // Flush of a held result
      out_ready = 1'b0;
      req(1'b1, 3'b000, 32'd9, 32'd9, 32'h40C, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      chk("flush_hold_valid", 64'(out_valid), 64'd1);
      flush = 1'b1;
      #1;
      chk("flush_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
      flush = 1'b0;
      out_ready = 1'b1;
      chk("flush_hold_cleared", 64'(out_valid), 64'd0);

      // Illegal func3 must not train the table
      pred_pc = 32'h510;
      req(1'b1, 3'b010, 32'd4, 32'd4, 32'h510, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      chk("illegal_flag", 64'(out_illegal), 64'd1);
      chk("illegal_taken", 64'(out_taken), 64'd0);
      @(negedge clk);
      req(1'b1, 3'b000, 32'd4, 32'd4, 32'h510, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      chk("illegal_no_update_pred", 64'(pred_taken), 64'd1);

      // Async reset while a result is held
      pred_pc = 32'h100;
      out_ready = 1'b0;
      req(1'b1, 3'b000, 32'd1, 32'd1, 32'h100, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      chk("prerst_valid", 64'(out_valid), 64'd1);
      chk("prerst_pred", 64'(pred_taken), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_valid", 64'(out_valid), 64'd0);
      chk("midrst_pred", 64'(pred_taken), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("postrst_valid", 64'(out_valid), 64'd0);
      chk("postrst_pred", 64'(pred_taken), 64'd0);

`ifdef BRU_PERF_CNT_EN
      chk("perf_rst_br", 64'(perf_branches), 64'd0);
      chk("perf_rst_mis", 64'(perf_mispredicts), 64'd0);
      req(1'b1, 3'b000, 32'd1, 32'd1, 32'h600, 1'b1);
      @(negedge clk);
      req(1'b1, 3'b000, 32'd1, 32'd2, 32'h600, 1'b1);
      @(negedge clk);
      req(1'b0, 3'b000, 32'd1, 32'd1, 32'h600, 1'b1);
      @(negedge clk);
      req(1'b1, 3'b000, 32'd1, 32'd2, 32'h600, 1'b1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("perf_branches", 64'(perf_branches), 64'd2);
      chk("perf_mispredicts", 64'(perf_mispredicts), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("perf_arst_br", 64'(perf_branches), 64'd0);
      chk("perf_arst_mis", 64'(perf_mispredicts), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
